// File: rtl/rtype_pkg.sv
// Shared constants for the R-type execute controller: opcode/funct codes,
// result-mux select values, FSM state encoding and the funct decoder.
package rtype_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SEL_ARITH = 2'd0;
    localparam logic [1:0] SEL_LOGIC = 2'd1;
    localparam logic [1:0] SEL_SHIFT = 2'd2;
    localparam logic [1:0] SEL_CMP   = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [1:0] sel;
    } dec_t;

    function automatic dec_t decode_rtype(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d.legal = (op == OP_RTYPE);
        d.sel   = SEL_ARITH;
        case (fn)
            FN_ADD, FN_SUB:                 d.sel = SEL_ARITH;
            FN_AND, FN_OR, FN_XOR, FN_NOR:  d.sel = SEL_LOGIC;
            FN_SLL, FN_SRL, FN_SRA:         d.sel = SEL_SHIFT;
            FN_SLT:                         d.sel = SEL_CMP;
            default:                        d.legal = 1'b0;
        endcase
        if (!d.legal) d.sel = SEL_ARITH;
        return d;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two registered read ports, one write port, entry 0 fixed
// at zero, plus a combinational debug read port.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [4:0]        ra_addr,
    input  logic [4:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [4:0]        w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem_reg [NREGS];

    // Every entry clears on reset, so each one is its own flop group.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset || gi == 0) begin
                    mem_reg[gi] <= '0;
                end else if (we && w_addr == 5'(gi)) begin
                    mem_reg[gi] <= w_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ra_data <= '0;
            rb_data <= '0;
        end else if (re) begin
            ra_data <= mem_reg[ra_addr];
            rb_data <= mem_reg[rb_addr];
        end
    end

    assign dbg_data = mem_reg[dbg_addr];

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type execute/write-back controller (IDLE->READ->EXEC->WB).
// Define OVF_TRAP_EN to suppress the write-back of overflowing add/sub.
module rtype_exec_ctrl
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] res_arith,
    output logic [DATA_W-1:0] res_logic,
    output logic [DATA_W-1:0] res_shift,
    output logic [DATA_W-1:0] res_cmp,
    output logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              illegal,
    output logic              ovf,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [1:0]        state_reg, state_next;
    logic [31:0]       instr_reg;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] arith_reg, logic_reg, shift_reg, cmp_reg;
    logic [DATA_W-1:0] arith_next, logic_next, shift_next, cmp_next;
    logic [DATA_W-1:0] sum, diff;
    logic [1:0]        sel_reg;
    logic              illegal_reg, ovf_reg, ovf_next, is_sub, wr_en;
    dec_t              dec;

    wire [5:0] op_f    = instr_reg[31:26];
    wire [4:0] rs_f    = instr_reg[25:21];
    wire [4:0] rt_f    = instr_reg[20:16];
    wire [4:0] rd_f    = instr_reg[15:11];
    wire [4:0] shamt_f = instr_reg[10:6];
    wire [5:0] fn_f    = instr_reg[5:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dec    = decode_rtype(op_f, fn_f);
        sum    = a_q + b_q;
        diff   = a_q - b_q;
        is_sub = (fn_f == FN_SUB);
        arith_next = is_sub ? diff : sum;
        // Signed overflow: result sign differs from A where the operand signs make it impossible.
        ovf_next = dec.legal && (dec.sel == SEL_ARITH) &&
                   (is_sub ? ((a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]))
                           : ((a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1]  != a_q[DATA_W-1])));
        case (fn_f[1:0])
            2'b00:   logic_next = a_q & b_q;
            2'b01:   logic_next = a_q | b_q;
            2'b10:   logic_next = a_q ^ b_q;
            default: logic_next = ~(a_q | b_q);
        endcase
        case (fn_f[1:0])
            2'b00:   shift_next = b_q << shamt_f;
            2'b10:   shift_next = b_q >> shamt_f;
            default: shift_next = $unsigned($signed(b_q) >>> shamt_f);
        endcase
        cmp_next = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        if (!dec.legal) begin
            arith_next = '0;
            logic_next = '0;
            shift_next = '0;
            cmp_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            instr_reg   <= '0;
            arith_reg   <= '0;
            logic_reg   <= '0;
            shift_reg   <= '0;
            cmp_reg     <= '0;
            sel_reg     <= SEL_ARITH;
            illegal_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && in_valid) instr_reg <= instr;
            if (state_reg == ST_EXEC) begin
                arith_reg   <= arith_next;
                logic_reg   <= logic_next;
                shift_reg   <= shift_next;
                cmp_reg     <= cmp_next;
                sel_reg     <= dec.sel;
                illegal_reg <= ~dec.legal;
                ovf_reg     <= ovf_next;
            end
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign done      = (state_reg == ST_WB);
    assign illegal   = done & illegal_reg;
    assign ovf       = done & ovf_reg;
    assign res_arith = arith_reg;
    assign res_logic = logic_reg;
    assign res_shift = shift_reg;
    assign res_cmp   = cmp_reg;
    assign wb_sel    = sel_reg;

`ifdef OVF_TRAP_EN
    assign wr_en = done && !illegal_reg && !ovf_reg && (rd_f != 5'd0);
`else
    assign wr_en = done && !illegal_reg && (rd_f != 5'd0);
`endif

    regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .re       (state_reg == ST_READ),
        .ra_addr  (rs_f),
        .rb_addr  (rt_f),
        .ra_data  (a_q),
        .rb_data  (b_q),
        .we       (wr_en),
        .w_addr   (rd_f),
        .w_data   (wb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Randomized self-checking bench for rtype_exec_ctrl with a behavioural
// register/ALU model and a model of the downstream 4-to-1 result mux.
module tb_rtype_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] res_arith, res_logic, res_shift, res_cmp;
    logic [1:0]  wb_sel;
    logic [31:0] wb_data;
    logic        done, illegal, ovf;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic        force_en;
    logic [31:0] force_val;
    logic [31:0] regs_m [32];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    rtype_exec_ctrl #(.DATA_W(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .res_arith(res_arith), .res_logic(res_logic),
        .res_shift(res_shift), .res_cmp(res_cmp), .wb_sel(wb_sel),
        .wb_data(wb_data), .done(done), .illegal(illegal), .ovf(ovf),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Downstream mux; force_en lets the bench inject arbitrary write-back data.
    always_comb begin
        case (wb_sel)
            2'd0:    wb_data = res_arith;
            2'd1:    wb_data = res_logic;
            2'd2:    wb_data = res_shift;
            default: wb_data = res_cmp;
        endcase
        if (force_en) wb_data = force_val;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference semantics of one R-type instruction.
    task automatic model_exec(input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                              output bit legal, output logic [1:0] sel,
                              output logic [31:0] res, output bit ov);
        longint      s;
        logic [63:0] wide;
        legal = 1; sel = 0; res = 0; ov = 0;
        if (op != 6'h00) begin
            legal = 0;
        end else begin
            case (fn)
                6'h20: begin s = longint'($signed(a)) + longint'($signed(b));
                             res = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'h22: begin s = longint'($signed(a)) - longint'($signed(b));
                             res = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'h24: begin sel = 1; res = a & b; end
                6'h25: begin sel = 1; res = a | b; end
                6'h26: begin sel = 1; res = a ^ b; end
                6'h27: begin sel = 1; res = ~(a | b); end
                6'h00: begin sel = 2; res = b << sh; end
                6'h02: begin sel = 2; res = b >> sh; end
                6'h03: begin sel = 2; wide = {{32{b[31]}}, b} >> sh; res = wide[31:0]; end
                6'h2A: begin sel = 3; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                default: legal = 0;
            endcase
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                             input bit frc, input logic [31:0] fval);
        bit          legal, ov, wr;
        logic [1:0]  sel;
        logic [31:0] res, got_res, wval;
        logic [4:0]  probe;
        model_exec(op, fn, regs_m[rs], regs_m[rt], sh, legal, sel, res, ov);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        instr = {op, rs, rt, rd, sh, fn}; in_valid = 1'b1;
        force_en = frc; force_val = fval;
        @(posedge clk);                        // acceptance edge, cycle 0
        @(negedge clk);                        // cycle 1
        in_valid = 1'($urandom_range(0, 1)); instr = $urandom;
        check_eq("done_c1", 32'(done), 32'd0);
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);
        @(negedge clk);                        // cycle 2
        check_eq("done_c2", 32'(done), 32'd0);
        @(negedge clk);                        // cycle 3
        in_valid = 1'b0;
        check_eq("done_c3", 32'(done), 32'd1);
        check_eq("illegal", 32'(illegal), 32'(!legal));
        check_eq("ovf", 32'(ovf), 32'(ov));
        check_eq("wb_sel", 32'(wb_sel), 32'(sel));
        if (legal) begin
            case (sel)
                2'd0:    got_res = res_arith;
                2'd1:    got_res = res_logic;
                2'd2:    got_res = res_shift;
                default: got_res = res_cmp;
            endcase
            check_eq("result", got_res, res);
        end else begin
            check_eq("zero_cands", res_arith | res_logic | res_shift | res_cmp, 32'd0);
        end
        wval = frc ? fval : res;
        wr = legal && (rd != 0);
`ifdef OVF_TRAP_EN
        if (ov) wr = 0;
`endif
        @(negedge clk);                        // cycle 4
        force_en = 1'b0;
        check_eq("in_ready_c4", 32'(in_ready), 32'd1);
        check_eq("done_c4", 32'(done), 32'd0);
        if (wr) regs_m[rd] = wval;
        dbg_addr = rd; #1;
        check_eq("dbg_rd", dbg_data, regs_m[rd]);
        probe = 5'($urandom_range(0, 31));
        dbg_addr = probe; #1;
        check_eq("dbg_probe", dbg_data, regs_m[probe]);
        $display("txn op=%h fn=%h rs=%0d rt=%0d rd=%0d sh=%0d sel=%0d res=%h ovf=%0d ill=%0d reg=%h",
                 op, fn, rs, rt, rd, sh, sel, res, ov, !legal, regs_m[rd]);
    endtask

    task automatic load_reg(input logic [4:0] rd, input logic [31:0] val);
        run_instr(6'h00, 5'd0, 5'd0, rd, 5'd0, 6'h20, 1'b1, val);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            check_eq(tag, dbg_data, 32'd0);
        end
    endtask

    logic [5:0] fn_tab [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h00, 6'h02, 6'h03, 6'h2A, 6'h3F};

    initial begin
        logic [5:0] rop, rfn;
        reset = 1'b1; in_valid = 1'b0; instr = '0; dbg_addr = '0;
        force_en = 1'b0; force_val = '0;
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cands", res_arith | res_logic | res_shift | res_cmp, 32'd0);
        check_eq("rst_wb_sel", 32'(wb_sel), 32'd0);
        check_all_zero("rst_regs");

        load_reg(5'd1, 32'd5);
        load_reg(5'd1, 32'h7FFF_FFFF);
        load_reg(5'd2, 32'd1);
        run_instr(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0, 32'd0);   // add overflow
        load_reg(5'd4, 32'hF000_0000);
        run_instr(6'h00, 5'd0, 5'd4, 5'd5, 5'd4, 6'h03, 1'b0, 32'd0);   // sra
        run_instr(6'h00, 5'd0, 5'd4, 5'd5, 5'd4, 6'h02, 1'b0, 32'd0);   // srl
        load_reg(5'd7, 32'd1);
        run_instr(6'h00, 5'd0, 5'd7, 5'd8, 5'd31, 6'h00, 1'b0, 32'd0);  // sll 31
        run_instr(6'h00, 5'd4, 5'd1, 5'd6, 5'd0, 6'h2A, 1'b0, 32'd0);   // slt neg<pos
        run_instr(6'h00, 5'd1, 5'd4, 5'd9, 5'd0, 6'h2A, 1'b0, 32'd0);   // slt swapped
        run_instr(6'h23, 5'd1, 5'd2, 5'd10, 5'd0, 6'h20, 1'b0, 32'd0);  // bad opcode
        run_instr(6'h00, 5'd1, 5'd2, 5'd11, 5'd0, 6'h3F, 1'b0, 32'd0);  // bad funct
        run_instr(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20, 1'b0, 32'd0);   // rd=0
        run_instr(6'h00, 5'd2, 5'd2, 5'd2, 5'd0, 6'h20, 1'b0, 32'd0);   // rd==rs==rt
        run_instr(6'h00, 5'd1, 5'd1, 5'd12, 5'd0, 6'h22, 1'b0, 32'd0);  // sub self

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                load_reg(5'($urandom_range(0, 31)), $urandom);
            end else begin
                rop = ($urandom_range(0, 15) == 0) ? 6'h23 : 6'h00;
                rfn = fn_tab[$urandom_range(0, 10)];
                run_instr(rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rfn, 1'b0, 32'd0);
            end
        end

        // Reset while a valid add sits in EXEC.
        @(negedge clk);
        instr = {6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h20}; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;          // cycle 2: EXEC
        @(negedge clk);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_ovf_ill", 32'({ovf, illegal}), 32'd0);
        @(negedge clk);
        check_eq("post_rst_done2", 32'(done), 32'd0);
        check_eq("post_rst_cands", res_arith | res_logic | res_shift | res_cmp, 32'd0);
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        check_all_zero("post_rst_regs");
        load_reg(5'd14, 32'hA5A5_0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rtype_exec_ctrl.md
Name: rtype_exec_ctrl

Overview:
Multi-cycle R-type execute/write-back controller for the single-issue processor datapath. Accepts one 32-bit R-type instruction per transaction, reads the internal 32x32 register file, and computes four candidate results. It drives those candidates and a 2-bit select into the downstream 4-to-1 result mux (mux4to1), then writes the mux output back to the register file. The block is the mux's upstream producer and its output's consumer.

Parameters:
DATA_W, 32, datapath and register width
NREGS, 32, register count (address width fixed at 5)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
in_valid  input  1  instruction offered
in_ready  output  1  block can accept (IDLE only)
instr  input  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
res_arith  output  DATA_W  mux input 0: add/sub result
res_logic  output  DATA_W  mux input 1: and/or/xor/nor result
res_shift  output  DATA_W  mux input 2: sll/srl/sra result
res_cmp  output  DATA_W  mux input 3: slt result (0 or 1)
wb_sel  output  2  mux select
wb_data  input  DATA_W  mux output, sampled in WB
done  output  1  one-cycle pulse, instruction retired
illegal  output  1  valid with done: unsupported opcode/funct
ovf  output  1  valid with done: signed add/sub overflow
dbg_addr  input  5  debug register read address
dbg_data  output  DATA_W  combinational read of reg[dbg_addr]; 0 for addr 0

Behaviour:
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE; no other transitions.
- IDLE: in_ready=1. On in_valid, latch instr at the edge and go to READ. in_ready is 0 in all other states, so a new instr cannot be accepted until the current one retires.
- READ: latch A=reg[rs] and B=reg[rt]. reg[0] reads as 0.
- EXEC: decode funct and register the candidates and wb_sel.
  - add 0x20 / sub 0x22 -> sel 0.
  - and 0x24 / or 0x25 / xor 0x26 / nor 0x27 -> sel 1.
  - sll 0x00 / srl 0x02 / sra 0x03 -> sel 2; operand B, amount shamt, sra sign-fills.
  - slt 0x2A -> sel 3; signed compare A<B gives 1, else 0.
- Candidates and wb_sel stay stable through WB.
- Arithmetic: DATA_W-bit two's-complement, wrap-around. ovf = signed overflow on add/sub only, 0 otherwise.
- illegal=1 when opcode!=0 or funct is unsupported. In that case: no write, wb_sel=0, all candidates 0.
- WB:
  - If not illegal and rd!=0, write reg[rd]=wb_data at the WB edge.
  - Writes to reg 0 are discarded.
  - done=1 for exactly this cycle; illegal/ovf are valid here and 0 otherwise.
- Latency: acceptance edge at cycle 0; done high in cycle 3; in_ready high again in cycle 4. Throughput 1 instruction per 4 cycles.
- rd==rs or rd==rt: operands were latched in READ, so write-back does not affect the current instruction. The next instruction sees the new value.
- Reset (any state, including mid-instruction): state=IDLE, all registers and latched operands 0, every output 0 except in_ready=1 in the cycle after reset deasserts. An in-flight instruction is dropped without a write.
- in_valid while busy: ignored, no buffering.
- dbg_data reflects writes from the cycle after the WB edge.

Optional Feature:
OVF_TRAP_EN
- Defined: add/sub with ovf=1 suppresses the register write; done still pulses with ovf=1.
- Undefined: the wrapped result is written and ovf is still reported.

Decomposition:
- Shared package rtype_pkg: funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLL, FN_SRL, FN_SRA), OP_RTYPE=0, mux select constants SEL_ARITH..SEL_CMP, FSM state encoding.
- One sub-module: regfile_2r1w (two registered read ports, one write port, reg0 hardwired 0, plus the combinational debug port).

Test Plan:
- Reset, then preload via add chain: add r1=r0+r0 while the bench drives wb_data=5 through a model mux. Response: dbg r1=5, done in cycle 3, in_ready back in cycle 4.
- r1=0x7FFFFFFF, r2=1, add r3,r1,r2. Response: wb_sel=0, res_arith=0x80000000, ovf=1. r3=0x80000000 without OVF_TRAP_EN; r3 unchanged with it.
- r4=0xF0000000, sra r5,r4,shamt=4. Response: res_shift=0xFF000000, wb_sel=2. Also srl gives 0x0F000000 and sll shamt=31 of 1 gives 0x80000000.
- slt r6,r4,r1 (negative < positive). Response: res_cmp=1, wb_sel=3, r6=1. Swapped operands give 0.
- opcode=0x23 or funct=0x3F. Response: illegal=1 with done, no register changes, all candidates 0. Also, add with rd=0 leaves r0=0.
- Assert reset during EXEC of a valid instruction. Response: no write, done never pulses, in_ready=1 one cycle after reset drops, and all regs read 0.
